// File: rtl/clock_pkg.sv
// clock_pkg: shared constants and configuration check for the time-digit counters
package clock_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;
    localparam int DOW_MOD  = 7;

    // A counter configuration is legal when MOD fits two BCD digits and the
    // binary width, and the reset value is a reachable count.
    function automatic bit cfg_ok(input int m, input int rv, input int w);
        return (m >= 2) && (m <= 100) && (rv >= 0) && (rv < m) &&
               (w >= 1) && (w < 31) && ((1 << w) >= m);
    endfunction

endpackage

// File: rtl/count_mod_bcd_if.sv
// count_mod_bcd_if: control inputs and count/status outputs of one time-digit field
interface count_mod_bcd_if #(
    parameter int WIDTH = 6
);
    logic             tick;
    logic             dir;
    logic             set_inc;
    logic             set_dec;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic             carry;
    logic             borrow;
    logic             load_err;
    logic             at_max;
    logic             at_zero;

    modport master (
        output tick, dir, set_inc, set_dec, load, load_val,
        input  cnt, bcd_tens, bcd_ones, carry, borrow, load_err, at_max, at_zero
    );

    modport slave (
        input  tick, dir, set_inc, set_dec, load, load_val,
        output cnt, bcd_tens, bcd_ones, carry, borrow, load_err, at_max, at_zero
    );
endinterface

// File: rtl/bin2bcd_2d.sv
// bin2bcd_2d: combinational binary 0..99 to two BCD digits by compare-subtract
module bin2bcd_2d (
    input  logic [6:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);
    logic [6:0] w_r1;
    logic [6:0] w_r2;
    logic [6:0] w_r3;
    logic       w_ge80;
    logic       w_ge40;
    logic       w_ge20;
    logic       w_ge10;

    // Peel off 80, 40, 20, 10 in turn; each hit sets one bit of the tens digit.
    always_comb begin
        w_ge80 = i_bin >= 7'd80;
        w_r1   = w_ge80 ? i_bin - 7'd80 : i_bin;
        w_ge40 = w_r1 >= 7'd40;
        w_r2   = w_ge40 ? w_r1 - 7'd40 : w_r1;
        w_ge20 = w_r2 >= 7'd20;
        w_r3   = w_ge20 ? w_r2 - 7'd20 : w_r2;
        w_ge10 = w_r3 >= 7'd10;
        o_tens = {w_ge80, w_ge40, w_ge20, w_ge10};
        o_ones = w_r3[3:0] - (w_ge10 ? 4'd10 : 4'd0);
    end
endmodule

// File: rtl/count_mod_bcd.sv
// count_mod_bcd: modulo-MOD up/down field counter with set, load, carry/borrow and BCD copy
module count_mod_bcd
    import clock_pkg::*;
#(
    parameter int MOD     = 60,
    parameter int WIDTH   = 6,
    parameter int RST_VAL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    count_mod_bcd_if.slave        bus
);
    localparam logic [WIDTH-1:0] W_MAX    = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] W_RST    = WIDTH'(RST_VAL);
    localparam logic [3:0]       RST_TENS = 4'(RST_VAL / 10);
    localparam logic [3:0]       RST_ONES = 4'(RST_VAL % 10);

    generate
        if (!cfg_ok(MOD, RST_VAL, WIDTH)) begin : g_bad_cfg
            $error("count_mod_bcd: illegal MOD/WIDTH/RST_VAL combination");
        end
    endgenerate

    logic [WIDTH-1:0] r_cnt;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_carry;
    logic             r_borrow;
    logic             r_lerr;

    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [3:0]       w_tens;
    logic [3:0]       w_ones;
    logic             w_max;
    logic             w_zero;
    logic             w_carry;
    logic             w_borrow;
    logic             w_lerr;

    assign w_max  = r_cnt == W_MAX;
    assign w_zero = r_cnt == '0;
    assign w_inc  = w_max ? '0 : r_cnt + 1'b1;
    assign w_dec  = w_zero ? W_MAX : r_cnt - 1'b1;

    // Next count by priority load > single set button > tick; only ticks wrap with a pulse.
    always_comb begin
        w_nxt    = r_cnt;
        w_carry  = 1'b0;
        w_borrow = 1'b0;
        w_lerr   = 1'b0;
        if (bus.load) begin
            w_lerr = bus.load_val > W_MAX;
            w_nxt  = w_lerr ? W_MAX : bus.load_val;
        end else if (bus.set_inc ^ bus.set_dec) begin
            w_nxt = bus.set_inc ? w_inc : w_dec;
        end else if (bus.tick) begin
            w_nxt    = (bus.dir == DIR_DOWN) ? w_dec : w_inc;
            w_carry  = (bus.dir == DIR_UP) && w_max;
            w_borrow = (bus.dir == DIR_DOWN) && w_zero;
        end
    end

    // BCD is taken from the next count so the digits land in the same cycle as cnt.
    bin2bcd_2d u_bcd (
        .i_bin  (7'(w_nxt)),
        .o_tens (w_tens),
        .o_ones (w_ones)
    );

    // Count, digits and one-cycle pulses, all updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= W_RST;
            r_tens   <= RST_TENS;
            r_ones   <= RST_ONES;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_lerr   <= 1'b0;
        end else begin
            r_cnt    <= w_nxt;
            r_tens   <= w_tens;
            r_ones   <= w_ones;
            r_carry  <= w_carry;
            r_borrow <= w_borrow;
            r_lerr   <= w_lerr;
        end
    end

    assign bus.cnt      = r_cnt;
    assign bus.bcd_tens = r_tens;
    assign bus.bcd_ones = r_ones;
    assign bus.carry    = r_carry;
    assign bus.borrow   = r_borrow;
    assign bus.load_err = r_lerr;
    assign bus.at_max   = w_max;
    assign bus.at_zero  = w_zero;
endmodule
